// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

    localparam int FETCH_PC_W  = 9;
    localparam int FETCH_INS_W = 32;
    localparam int PC_STEP     = 4;

    typedef struct packed {
        logic [FETCH_PC_W-1:0]  pc;
        logic [FETCH_INS_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetched {pc, instr} entries; clear wins over push and pop.
// The head is read combinationally so an entry is visible the cycle after it is written.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter type entry_t = fetch_entry_t,
    parameter int  DEPTH   = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   clear,
    input  entry_t                 wdata,
    output entry_t                 head,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    entry_t             mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_reg;
    logic [PTR_W-1:0]   rd_ptr_reg;
    logic [CNT_W-1:0]   count_reg;
    logic               full;
    logic               empty;
    logic               do_push;
    logic               do_pop;

    assign full    = (count_reg == CNT_W'(DEPTH));
    assign empty   = (count_reg == '0);
    assign do_push = push & ~clear;
    assign do_pop  = pop & ~clear & ~empty;

    // Pointers are power-of-two wide, so they wrap modulo DEPTH on their own.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (clear) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            count_reg <= count_reg + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= wdata;
        end
    end

    assign head  = empty ? '0 : mem[rd_ptr_reg];
    assign count = count_reg;

    overflow_chk : assert property (@(posedge clk) disable iff (!reset)
        (push && !clear) |-> (!full || pop));

    underflow_chk : assert property (@(posedge clk) disable iff (!reset)
        (pop && !clear) |-> !empty);

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: owns the PC, issues one imem read per cycle and
// queues returned {pc, instr} pairs for decode, with redirect flush and halt-with-drain.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int              PC_W     = 9,
    parameter int              INS_W    = 32,
    parameter int              DEPTH    = 4,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic                   clk,
    input  logic                   reset,
    output logic                   imem_req,
    output logic [PC_W-1:0]        imem_addr,
    input  logic [INS_W-1:0]       imem_rdata,
    input  logic                   redirect_valid,
    input  logic [PC_W-1:0]        redirect_pc,
    input  logic                   halt,
    output logic                   id_valid,
    input  logic                   id_ready,
    output logic [PC_W-1:0]        id_pc,
    output logic [INS_W-1:0]       id_instr,
    output logic [$clog2(DEPTH):0] occupancy,
    output logic                   halted
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int SUM_W = CNT_W + 1;

    typedef struct packed {
        logic [PC_W-1:0]  pc;
        logic [INS_W-1:0] instr;
    } entry_t;

    logic [PC_W-1:0]  pc_reg;
    logic [PC_W-1:0]  pc_next;
    logic             inflight_reg;
    logic [PC_W-1:0]  inflight_pc_reg;
    logic             halted_reg;

    logic             pop;
    logic             push;
    logic [SUM_W-1:0] demand;
    logic             issue_ok;
    entry_t           wdata;
    entry_t           head;
    logic [CNT_W-1:0] count;

    // A pop coinciding with a redirect is discarded along with the rest of the queue.
    assign pop  = id_valid & id_ready & ~redirect_valid;
    // The response for last cycle's request is killed by a redirect this cycle.
    assign push = inflight_reg & ~redirect_valid;

    // Entries that will occupy the queue once everything already requested lands.
    assign demand   = SUM_W'(count) + SUM_W'(inflight_reg) - SUM_W'(pop);
    assign issue_ok = (demand < SUM_W'(DEPTH));

    // Gating with reset keeps the request low while reset is asserted.
    assign imem_req  = reset & ~halt & ~redirect_valid & issue_ok;
    assign imem_addr = pc_reg;

    always_comb begin
        pc_next = pc_reg;
        if (redirect_valid) begin
            pc_next = {redirect_pc[PC_W-1:2], 2'b00};
        end else if (imem_req) begin
            pc_next = pc_reg + PC_W'(PC_STEP);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_reg          <= RESET_PC;
            inflight_reg    <= 1'b0;
            inflight_pc_reg <= '0;
            halted_reg      <= 1'b0;
        end else begin
            pc_reg          <= pc_next;
            inflight_reg    <= imem_req;
            inflight_pc_reg <= pc_reg;
            halted_reg      <= halt & ~imem_req;
        end
    end

    assign wdata.pc    = inflight_pc_reg;
    assign wdata.instr = imem_rdata;

    fetch_fifo #(
        .entry_t (entry_t),
        .DEPTH   (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .clear (redirect_valid),
        .wdata (wdata),
        .head  (head),
        .count (count)
    );

    assign id_valid  = (count != '0);
    assign id_pc     = head.pc;
    assign id_instr  = head.instr;
    assign occupancy = count;
    assign halted    = halted_reg;

endmodule

// File: tb/tb_fetch_queue.sv
// Randomised bench for fetch_queue against a queue-based reference model of the fetch rules.
module tb_fetch_queue;

    localparam int PC_W  = 9;
    localparam int INS_W = 32;
    localparam int DEPTH = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              imem_req;
    logic [PC_W-1:0]   imem_addr;
    logic [INS_W-1:0]  imem_rdata = '0;
    logic              redirect_valid = 1'b0;
    logic [PC_W-1:0]   redirect_pc = '0;
    logic              halt = 1'b0;
    logic              id_valid;
    logic              id_ready = 1'b0;
    logic [PC_W-1:0]   id_pc;
    logic [INS_W-1:0]  id_instr;
    logic [$clog2(DEPTH):0] occupancy;
    logic              halted;

    int checks = 0;
    int errors = 0;

    fetch_queue #(
        .PC_W     (PC_W),
        .INS_W    (INS_W),
        .DEPTH    (DEPTH),
        .RESET_PC (9'h000)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt           (halt),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_pc          (id_pc),
        .id_instr       (id_instr),
        .occupancy      (occupancy),
        .halted         (halted)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [8:0] a);
        return 32'h5A00_0000 ^ (32'(a) * 32'h9E37_79B1);
    endfunction

    // Instruction memory with one cycle of read latency.
    always @(posedge clk) begin
        if (imem_req) imem_rdata <= instr_of(imem_addr);
    end

    // Reference model: what decode should see, what is requested, and the PC.
    typedef struct {
        logic [8:0]  pc;
        logic [31:0] instr;
    } ent_t;

    ent_t       q[$];
    bit         pend;
    logic [8:0] pend_pc;
    logic [8:0] pc_m;
    bit         halted_m;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        pend     = 1'b0;
        pend_pc  = '0;
        pc_m     = 9'h000;
        halted_m = 1'b0;
    endtask

    task automatic check_outputs(input bit exp_req);
        check("imem_req", imem_req, exp_req);
        check("imem_addr", imem_addr, pc_m);
        check("id_valid", id_valid, q.size() != 0);
        check("id_pc", id_pc, (q.size() != 0) ? q[0].pc : 9'd0);
        check("id_instr", id_instr, (q.size() != 0) ? q[0].instr : 32'd0);
        check("occupancy", occupancy, q.size());
        check("halted", halted, halted_m);
    endtask

    // One clock cycle: drive inputs after the falling edge, check, then advance the model.
    task automatic step(input bit rv, input logic [8:0] rpc, input bit h, input bit rdy, input bit rst_n);
        bit pop_m;
        bit req_m;
        int demand;
        @(negedge clk);
        reset          = rst_n;
        redirect_valid = rv;
        redirect_pc    = rpc;
        halt           = h;
        id_ready       = rdy;
        #1;
        if (!reset) begin
            model_reset();
            check_outputs(1'b0);
            return;
        end
        pop_m  = (q.size() != 0) && rdy && !rv;
        demand = q.size() + int'(pend) - int'(pop_m);
        req_m  = !h && !rv && (demand < DEPTH);
        check_outputs(req_m);
        if (rv) begin
            q.delete();
            pend = 1'b0;
            pc_m = rpc & 9'h1FC;
        end else begin
            if (pop_m) void'(q.pop_front());
            if (pend) q.push_back('{pend_pc, instr_of(pend_pc)});
            pend    = req_m;
            pend_pc = pc_m;
            if (req_m) pc_m = pc_m + 9'd4;
        end
        halted_m = h && !req_m;
    endtask

    // Reset asserted between clock edges must clear the outputs without waiting for a clock.
    task automatic async_reset_check();
        @(negedge clk);
        #3;
        reset = 1'b0;
        #1;
        model_reset();
        check_outputs(1'b0);
    endtask

    task automatic random_run(input int n, input int rdy_pct);
        bit h = 1'b0;
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 19) == 0) h = !h;
            step($urandom_range(0, 15) == 0, 9'($urandom), h,
                 $urandom_range(0, 99) < rdy_pct, 1'b1);
        end
    endtask

    initial begin
        model_reset();
        repeat (3) step(1'b0, 9'h0, 1'b0, 1'b1, 1'b0);

        // Streaming start-up and steady state.
        repeat (20) step(1'b0, 9'h0, 1'b0, 1'b1, 1'b1);

        // Back-pressure saturates the queue, then drains without gaps.
        repeat (10) step(1'b0, 9'h0, 1'b0, 1'b0, 1'b1);
        repeat (10) step(1'b0, 9'h0, 1'b0, 1'b1, 1'b1);

        // Redirect with three entries queued and one fetch outstanding.
        step(1'b1, 9'h000, 1'b0, 1'b1, 1'b1);
        repeat (4) step(1'b0, 9'h0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 9'h0A6, 1'b0, 1'b0, 1'b1);
        repeat (6) step(1'b0, 9'h0, 1'b0, 1'b1, 1'b1);

        // Halt with two entries queued and one in flight, then resume.
        step(1'b1, 9'h040, 1'b0, 1'b1, 1'b1);
        repeat (3) step(1'b0, 9'h0, 1'b0, 1'b0, 1'b1);
        repeat (8) step(1'b0, 9'h0, 1'b1, 1'b1, 1'b1);
        repeat (6) step(1'b0, 9'h0, 1'b0, 1'b1, 1'b1);

        // Redirect while halted moves the PC but issues nothing.
        repeat (2) step(1'b0, 9'h0, 1'b1, 1'b1, 1'b1);
        step(1'b1, 9'h123, 1'b1, 1'b1, 1'b1);
        repeat (3) step(1'b0, 9'h0, 1'b1, 1'b1, 1'b1);
        repeat (6) step(1'b0, 9'h0, 1'b0, 1'b1, 1'b1);

        // PC wraps from 0x1FC to 0x000.
        step(1'b1, 9'h1F0, 1'b0, 1'b1, 1'b1);
        repeat (10) step(1'b0, 9'h0, 1'b0, 1'b1, 1'b1);

        random_run(400, 75);

        // Asynchronous reset with a full queue, then restart from RESET_PC.
        repeat (8) step(1'b0, 9'h0, 1'b0, 1'b0, 1'b1);
        async_reset_check();
        repeat (2) step(1'b0, 9'h0, 1'b0, 1'b1, 1'b0);
        repeat (10) step(1'b0, 9'h0, 1'b0, 1'b1, 1'b1);

        random_run(300, 50);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Parametrised instruction-fetch front end that replaces the bare PC register / PC mux / IF-ID register arrangement of the current pipeline.
- Owns the PC and issues one request per cycle to a synchronous instruction memory with 1-cycle read latency.
- Buffers returned {pc, instr} pairs in a DEPTH-entry queue and presents them to decode over a valid/ready handshake.
- Supports redirect (branch/jump flush), decode back-pressure and halt-with-drain.

Parameters:
- PC_W, 9: PC / instruction-memory byte-address width.
- INS_W, 32: instruction width.
- DEPTH, 4: queue entries; power of 2, at least 2.
- RESET_PC, 0: PC value loaded on reset.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- imem_req  out  1  fetch request this cycle.
- imem_addr  out  PC_W  fetch byte address (the current PC).
- imem_rdata  in  INS_W  instruction; valid the cycle after imem_req.
- redirect_valid  in  1  flush plus new PC, from the branch unit.
- redirect_pc  in  PC_W  redirect target.
- halt  in  1  level; stop issuing new fetches.
- id_valid  out  1  head entry valid.
- id_ready  in  1  decode accepts the head entry.
- id_pc  out  PC_W  PC of the head entry.
- id_instr  out  INS_W  instruction of the head entry.
- occupancy  out  $clog2(DEPTH)+1  entries currently queued.
- halted  out  1  halt is active and no fetch is in flight.

Behaviour:
- Reset (async assert, sync release):
  - pc = RESET_PC; queue empty; inflight = 0.
  - Outputs: imem_req = 0, imem_addr = RESET_PC, id_valid = 0, id_pc = 0, id_instr = 0, occupancy = 0, halted = 0.
  - Reset mid-operation discards all entries and any in-flight fetch.
- Pop: occurs when id_valid & id_ready.
- Issue:
  - Condition: imem_req = !halt & !redirect_valid & (occupancy + inflight - pop < DEPTH).
  - On issue: pc <= pc + 4, modulo 2^PC_W (wraps silently).
  - inflight <= imem_req. The rdata for the request is enqueued with its PC at the end of the following cycle.
- Latency:
  - A request in cycle N is enqueued at the end of N+1; id_valid is high in N+2. There is no bypass.
  - First id_valid is 2 cycles after reset release.
  - With id_ready held at 1, sustained throughput is 1 instruction/cycle.
- Head outputs: id_pc/id_instr show the head entry; both are 0 when the queue is empty.
- Back-pressure: when id_ready = 0, the head is held stable and issue stops once the occupancy term reaches DEPTH. No entry is ever lost or duplicated.
- Redirect (single cycle, highest priority):
  - Queue is cleared and occupancy = 0 next cycle.
  - The in-flight response is killed (not enqueued).
  - pc <= {redirect_pc[PC_W-1:2], 2'b00}; no request is issued in the redirect cycle.
  - Fetch resumes the next cycle, so the first target instruction reaches decode 3 cycles after redirect.
  - A pop in the same cycle as a redirect is ignored.
- Halt:
  - No new requests are issued.
  - An outstanding in-flight response still enqueues.
  - Queue keeps draining to decode.
  - halted = halt & !inflight (registered view).
  - Deasserting halt resumes fetch at the held pc.
  - A redirect during halt updates pc and flushes, but issues no fetch.
- Simultaneous enqueue and pop when full: legal, occupancy unchanged. Enqueue is never attempted when full, by the issue rule.
- Queue pointers wrap modulo DEPTH.
- Overflow/underflow: assertions fire on enqueue when full and on pop when empty.

Decomposition:
- Package fetch_pkg:
  - fetch_entry_t struct {pc [PC_W-1:0], instr [INS_W-1:0]}.
  - Constant PC_STEP = 4.
- Sub-module fetch_fifo:
  - Parametrised synchronous FIFO of fetch_entry_t.
  - Inputs: push, pop, clear. Outputs: head, count.
  - Clear takes priority over push and pop.
- Top level holds the PC, inflight/kill logic, issue arbitration and halted.

Test Plan:
- Reset release, id_ready = 1, imem returns mem[addr]: requests at addresses 0, 4, 8, ...; first id_valid 2 cycles after release with id_pc = 0; then 1 instruction/cycle.
- id_ready = 0 for 10 cycles, DEPTH = 4: occupancy saturates at 4 and imem_req drops. On release, id_pc sequence 0, 4, 8, 12, 16 has no gap or duplicate.
- Redirect to 0x0A6 while 3 entries are queued and one fetch is in flight:
  - Next cycle occupancy = 0 and the stale response is dropped.
  - imem_addr = 0x0A4.
  - First id_pc = 0x0A4, 3 cycles after the redirect.
- Halt asserted with one fetch in flight and 2 entries queued: in-flight enqueues and all 3 entries drain; imem_req stays 0; halted = 1. Deassert halt: fetch resumes at the next sequential PC.
- pc = 0x1FC with PC_W = 9: next fetch address is 0x000.
- Assert reset mid-stream with a full queue: all outputs reach reset values immediately (asynchronously); after release, fetch restarts at RESET_PC.
